// File: rtl/fir_load_ctrl.sv
// ---------------------------------------------------------------------------
// fir_load_ctrl
//
// Sequences an external transposed-form FIR filter. Coefficients are staged
// in a local bank, shifted into the filter on request, the filter
// accumulators are flushed with zeros, and then samples stream through with
// a valid pipe that tracks which filter outputs belong to real input samples.
//
// Parameters
//   W1 : sample and coefficient width
//   W4 : filter output width
//   L  : filter length (coefficient address is 4 bits wide)
//
// Ports
//   clk        : clock, all registers on the rising edge
//   reset      : asynchronous, active-high reset
//   coef_we    : coefficient bank write strobe (ignored while busy)
//   coef_addr  : bank index 0..L-1 (out-of-range writes are ignored)
//   coef_wdata : coefficient value to write
//   start      : one-cycle request to load the bank into the filter
//   busy       : high while coefficients load or the filter flushes
//   s_valid    : input sample available
//   s_data     : input sample
//   s_ready    : high only while streaming; accept = s_valid && s_ready
//   fir_load_x : registered mode to the filter, 0 = coefficient shift,
//                1 = sample run
//   fir_c      : registered coefficient to the filter
//   fir_x      : registered sample to the filter (zero for bubbles)
//   fir_y      : filter output
//   m_valid    : output strobe, no backpressure
//   m_data     : registered filter output
// ---------------------------------------------------------------------------
module fir_load_ctrl #(
    parameter int W1 = 9,
    parameter int W4 = 11,
    parameter int L  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coef_we,
    input  logic [3:0]           coef_addr,
    input  logic signed [W1-1:0] coef_wdata,
    input  logic                 start,
    output logic                 busy,
    input  logic                 s_valid,
    input  logic signed [W1-1:0] s_data,
    output logic                 s_ready,
    output logic                 fir_load_x,
    output logic signed [W1-1:0] fir_c,
    output logic signed [W1-1:0] fir_x,
    input  logic signed [W4-1:0] fir_y,
    output logic                 m_valid,
    output logic signed [W4-1:0] m_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_PHASE = 4'(L - 1);

    state_t               state_q;
    state_t               state_d;
    logic [3:0]           phaseCnt_q;
    logic [3:0]           phaseCnt_d;
    logic signed [W1-1:0] bank_q [L];
    logic                 firLoadX_q;
    logic signed [W1-1:0] firC_q;
    logic signed [W1-1:0] firX_q;
    logic [2:0]           validPipe_q;
    logic                 mValid_q;
    logic signed [W4-1:0] mData_q;

    logic                 accept;
    logic                 bankWe;
    logic                 pipeClear;

    // A start seen while streaming drops s_ready in that same cycle, so no
    // sample is accepted on the edge that leaves RUN; the same condition
    // discards everything still travelling through the filter.
    assign busy      = (state_q == LOAD) || (state_q == FLUSH);
    assign s_ready   = (state_q == RUN) && !start;
    assign accept    = s_valid && s_ready;
    assign pipeClear = (state_q == RUN) && start;
    assign bankWe    = coef_we && !busy && (32'(coef_addr) < 32'(L));

    assign fir_load_x = firLoadX_q;
    assign fir_c      = firC_q;
    assign fir_x      = firX_q;
    assign m_valid    = mValid_q;
    assign m_data     = mData_q;

    // Next-state logic. The phase counter times both LOAD and FLUSH, each
    // lasting exactly L cycles, and returns to zero whenever one of those
    // states is left.
    always_comb begin
        state_d    = state_q;
        phaseCnt_d = phaseCnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    phaseCnt_d = '0;
                end
            end
            LOAD: begin
                if (phaseCnt_q == LAST_PHASE) begin
                    state_d    = FLUSH;
                    phaseCnt_d = '0;
                end else begin
                    phaseCnt_d = phaseCnt_q + 4'd1;
                end
            end
            FLUSH: begin
                if (phaseCnt_q == LAST_PHASE) begin
                    state_d    = RUN;
                    phaseCnt_d = '0;
                end else begin
                    phaseCnt_d = phaseCnt_q + 4'd1;
                end
            end
            RUN: begin
                if (start) begin
                    state_d    = LOAD;
                    phaseCnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                phaseCnt_d = '0;
            end
        endcase
    end

    // State register and phase counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            phaseCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            phaseCnt_q <= phaseCnt_d;
        end
    end

    // Coefficient bank. Writes are only taken while the bank is not being
    // shifted out, so a load always sees one consistent coefficient set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < L; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bankWe) begin
            bank_q[coef_addr] <= coef_wdata;
        end
    end

    // Filter-facing registers are computed from the next state so they line
    // up with the state they belong to: in the k-th LOAD cycle fir_c already
    // holds bank entry k. Entry 0 goes out first and therefore ends up in
    // filter tap 0 after the full shift. Outside LOAD fir_c keeps its value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            firLoadX_q <= 1'b1;
            firC_q     <= '0;
            firX_q     <= '0;
        end else begin
            firLoadX_q <= (state_d != LOAD);
            if (state_d == LOAD) begin
                firC_q <= bank_q[phaseCnt_d];
            end
            firX_q <= accept ? s_data : '0;
        end
    end

    // Valid pipe: stage 0 matches the fir_x register, stage 1 the filter x
    // register, stage 2 the filter accumulator, and m_valid the m_data
    // register. Bubbles and LOAD/FLUSH cycles never set stage 0, so their
    // outputs are never flagged valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validPipe_q <= '0;
            mValid_q    <= 1'b0;
            mData_q     <= '0;
        end else begin
            if (pipeClear) begin
                validPipe_q <= '0;
                mValid_q    <= 1'b0;
            end else begin
                validPipe_q <= {validPipe_q[1:0], accept};
                mValid_q    <= validPipe_q[2];
            end
            mData_q <= fir_y;
        end
    end

endmodule

// File: tb/tb_fir_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_load_ctrl
//
// Drives fir_load_ctrl against a behavioural transposed-form FIR filter and
// compares every cycle against a reference that works from the controller's
// rules: a busy window of 2L cycles after start (first L of them shifting the
// bank), then streaming where each output is the convolution of the loaded
// coefficients with the filter input history, valid four cycles after the
// accepting cycle.
// ---------------------------------------------------------------------------
module tb_fir_load_ctrl;

    localparam int W1 = 9;
    localparam int W4 = 11;
    localparam int L  = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          coef_we;
    logic [3:0]    coef_addr;
    logic [W1-1:0] coef_wdata;
    logic          start;
    logic          busy;
    logic          s_valid;
    logic [W1-1:0] s_data;
    logic          s_ready;
    logic          fir_load_x;
    logic [W1-1:0] fir_c;
    logic [W1-1:0] fir_x;
    logic [W4-1:0] fir_y;
    logic          m_valid;
    logic [W4-1:0] m_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            mState;       // 0 idle, 1 busy, 2 streaming
    int            busyCnt;
    int            bankM [L];
    int            loaded [L];
    int            xhist [$];
    logic          pV [4];
    logic [W4-1:0] pD [4];
    logic          expLoadX;
    logic [W1-1:0] expFirC;

    // Observation bookkeeping
    int            tickNo = 0;
    int            busyCycles;
    int            loadLowCycles;
    int            nAcc;
    int            nOut;
    logic [W4-1:0] outQ [$];
    int            validTicks [$];

    always #5 clk = ~clk;

    fir_load_ctrl #(.W1(W1), .W4(W4), .L(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .start      (start),
        .busy       (busy),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .fir_load_x (fir_load_x),
        .fir_c      (fir_c),
        .fir_x      (fir_x),
        .fir_y      (fir_y),
        .m_valid    (m_valid),
        .m_data     (m_data)
    );

    // Behavioural filter: coefficients shift in from the top tap while
    // fir_load_x is low; otherwise a registered x feeds a transposed
    // accumulator chain whose tap-0 sum, scaled down by 2^8, is the output.
    int cF [L];
    int aF [L];
    int xF;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < L; k++) begin
                cF[k] <= 0;
                aF[k] <= 0;
            end
            xF <= 0;
        end else if (!fir_load_x) begin
            for (int k = 0; k < L - 1; k++) begin
                cF[k] <= cF[k+1];
            end
            cF[L-1] <= int'($signed(fir_c));
        end else begin
            xF <= int'($signed(fir_x));
            for (int k = 0; k < L - 1; k++) begin
                aF[k] <= aF[k+1] + cF[k] * xF;
            end
            aF[L-1] <= cF[L-1] * xF;
        end
    end

    assign fir_y = W4'(aF[0] >>> 8);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        mState  = 0;
        busyCnt = 0;
        for (int k = 0; k < L; k++) begin
            bankM[k]  = 0;
            loaded[k] = 0;
        end
        xhist.delete();
        for (int i = 0; i < 4; i++) begin
            pV[i] = 1'b0;
            pD[i] = '0;
        end
        expLoadX = 1'b1;
        expFirC  = '0;
    endtask

    // Output for the newest filter input: sum of c[k] * x[n-k], scaled.
    function automatic int convRef();
        int sum;
        int n;
        sum = 0;
        n   = xhist.size();
        for (int k = 0; k < L; k++) begin
            if (k < n) sum += loaded[k] * xhist[n-1-k];
        end
        return sum >>> 8;
    endfunction

    task automatic checkResetValues();
        chk("rst_fir_load_x", 32'(fir_load_x), 32'(1));
        chk("rst_fir_c",      32'(fir_c),      32'(0));
        chk("rst_fir_x",      32'(fir_x),      32'(0));
        chk("rst_busy",       32'(busy),       32'(0));
        chk("rst_s_ready",    32'(s_ready),    32'(0));
        chk("rst_m_valid",    32'(m_valid),    32'(0));
        chk("rst_m_data",     32'(m_data),     32'(0));
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance the
    // reference model across the edge, then check the registered outputs.
    task automatic applyStimulus(input logic sv, input logic [W1-1:0] sd, input logic st,
                                 input logic we, input logic [3:0] wa, input logic [W1-1:0] wd);
        logic          expBusy;
        logic          expReady;
        logic          acc;
        logic [W4-1:0] y;
        logic [W1-1:0] expFirX;
        s_valid    = sv;
        s_data     = sd;
        start      = st;
        coef_we    = we;
        coef_addr  = wa;
        coef_wdata = wd;
        #1;
        expBusy  = (mState == 1);
        expReady = (mState == 2) && !st;
        chk("busy",    32'(busy),    32'(expBusy));
        chk("s_ready", 32'(s_ready), 32'(expReady));
        if (busy) busyCycles++;
        if (!fir_load_x) loadLowCycles++;
        acc = expReady && sv;
        if (acc) nAcc++;
        y = '0;
        if (mState == 2 && st) begin
            for (int i = 0; i < 4; i++) pV[i] = 1'b0;
            mState  = 1;
            busyCnt = 0;
            loaded  = bankM;
        end else begin
            if (mState == 2) begin
                xhist.push_back(acc ? int'($signed(sd)) : 0);
                y = W4'(convRef());
            end
            for (int i = 3; i > 0; i--) begin
                pV[i] = pV[i-1];
                pD[i] = pD[i-1];
            end
            pV[0] = acc;
            pD[0] = y;
            if (mState == 0 && st) begin
                mState  = 1;
                busyCnt = 0;
                loaded  = bankM;
            end else if (mState == 1) begin
                busyCnt++;
                if (busyCnt == 2 * L) begin
                    mState = 2;
                    xhist.delete();
                end
            end
        end
        if (we && !expBusy && int'(wa) < L) bankM[wa] = int'($signed(wd));
        expFirX = acc ? sd : '0;
        if (mState == 1 && busyCnt < L) begin
            expLoadX = 1'b0;
            expFirC  = W1'(loaded[busyCnt]);
        end else begin
            expLoadX = 1'b1;
        end
        @(posedge clk);
        #1;
        tickNo++;
        checkOutput(expFirX);
    endtask

    task automatic checkOutput(input logic [W1-1:0] expFirX);
        chk("fir_load_x", 32'(fir_load_x), 32'(expLoadX));
        chk("fir_c",      32'(fir_c),      32'(expFirC));
        chk("fir_x",      32'(fir_x),      32'(expFirX));
        chk("m_valid",    32'(m_valid),    32'(pV[3]));
        if (m_valid) begin
            nOut++;
            outQ.push_back(m_data);
            validTicks.push_back(tickNo);
        end
        if (pV[3]) chk("m_data", 32'(m_data), 32'(pD[3]));
    endtask

    task automatic idleTick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0, '0);
    endtask

    // Start a load; optionally hammer the bank with writes while busy.
    task automatic loadBank(input bit noise);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, '0);
        repeat (2 * L) applyStimulus(1'b0, '0, 1'b0, noise, 4'($urandom), W1'($urandom));
    endtask

    // Single 16 followed by valid zeros: with bank[k] = 16*(k+1) the outputs
    // are 1..15 then 0. The accepting cycle is cycle 0; its output shows in
    // cycle 4, i.e. after the third following edge.
    task automatic impulseRun();
        int t0;
        outQ.delete();
        validTicks.delete();
        applyStimulus(1'b1, W1'(16), 1'b0, 1'b0, 4'd0, '0);
        t0 = tickNo;
        repeat (L) applyStimulus(1'b1, '0, 1'b0, 1'b0, 4'd0, '0);
        repeat (4) idleTick();
        chk("impulse_count", 32'(outQ.size()), 32'(L + 1));
        if (outQ.size() >= L + 1) begin
            chk("impulse_latency", 32'(validTicks[0] - t0), 32'(3));
            for (int k = 0; k <= L; k++) begin
                chk("impulse_tap", 32'(outQ[k]), (k < L) ? 32'(k + 1) : 32'(0));
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        start      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        resetModel();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkResetValues();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Load an all-zero bank: 2L busy cycles, L of them shifting
        busyCycles    = 0;
        loadLowCycles = 0;
        loadBank(1'b0);
        idleTick();
        chk("busy_cycles",     32'(busyCycles),    32'(2 * L));
        chk("load_low_cycles", 32'(loadLowCycles), 32'(L));

        // Impulse response through bank[k] = 16*(k+1)
        for (int k = 0; k < L; k++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'(k), W1'(16 * (k + 1)));
        end
        loadBank(1'b0);
        impulseRun();

        // Bubbles: s_valid 1,0,1,0,... and nothing lost
        nAcc = 0;
        nOut = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'((i % 2) == 0), W1'($urandom), 1'b0, 1'b0, 4'd0, '0);
        end
        repeat (4) idleTick();
        chk("bubble_accepted", 32'(nAcc), 32'(4));
        chk("bubble_outputs",  32'(nOut), 32'(4));

        // Out-of-range write, writes while busy, then reload: bank unchanged
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd15, W1'($urandom));
        loadBank(1'b1);
        impulseRun();

        // Start with three samples in flight: all discarded
        repeat (4) idleTick();
        nOut = 0;
        repeat (3) applyStimulus(1'b1, W1'($urandom), 1'b0, 1'b0, 4'd0, '0);
        applyStimulus(1'b1, W1'($urandom), 1'b1, 1'b0, 4'd0, '0);
        repeat (2 * L) idleTick();
        chk("inflight_outputs", 32'(nOut), 32'(0));

        // Random coefficients and random stream
        for (int k = 0; k < L; k++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'(k), W1'($urandom));
        end
        loadBank(1'b0);
        repeat (60) applyStimulus(1'($urandom_range(0, 3) != 0), W1'($urandom), 1'b0, 1'b0, 4'd0, '0);
        repeat (5) idleTick();

        // Reset during LOAD cycle 7 takes effect immediately
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, '0);
        repeat (6) idleTick();
        chk("pre_reset_load_x", 32'(fir_load_x), 32'(0));
        #2;
        reset = 1'b1;
        #1;
        checkResetValues();
        resetModel();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // After reset the bank is zero and the controller starts from IDLE
        idleTick();
        loadBank(1'b0);
        applyStimulus(1'b1, W1'(100), 1'b0, 1'b0, 4'd0, '0);
        repeat (5) idleTick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
